// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, state encoding and opcode legality check for alu_seq
package alu_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_SLL = 4'b0100;
  localparam logic [3:0] ALU_SRL = 4'b0101;
  localparam logic [3:0] ALU_XOR = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SRA = 4'b1000;
  localparam logic [3:0] ALU_MUL = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  function automatic logic op_is_legal(input logic [3:0] op);
    return op <= ALU_MUL;
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// rtl/alu_seq_if.sv - operand/result handshake bundle between a pipeline stage and alu_seq
interface alu_seq_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data1;
  logic [WIDTH-1:0] data2;
  logic [3:0]       ALUctrl;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] alu_result;
  logic             zero;
  logic             ovf;
  logic             illegal;

  modport master (
    output in_valid, data1, data2, ALUctrl, out_ready,
    input  in_ready, out_valid, alu_result, zero, ovf, illegal
  );

  modport slave (
    input  in_valid, data1, data2, ALUctrl, out_ready,
    output in_ready, out_valid, alu_result, zero, ovf, illegal
  );
endinterface

// File: rtl/alu_seq_mul.sv
// rtl/alu_seq_mul.sv - iterative shift-add multiplier, one multiplier bit per clock
module alu_seq_mul #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             done,
  output logic [WIDTH-1:0] product
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;

  // done stays up for the one cycle the owner spends registering the product
  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_q;

  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    if (start) begin
      mcand_d  = multiplicand;
      mplier_d = multiplier;
      acc_d    = '0;
      cnt_d    = '0;
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (done) begin
        busy_d = 1'b0;
      end else begin
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - handshaked ALU with registered result/flags and an iterative MUL
module alu_seq
  import alu_pkg::*;
#(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input logic     clk,
  input logic     rst_n,
  alu_seq_if.slave bus
);
  state_e           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;

  logic             accept;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_product;
  logic [WIDTH-1:0] op_result;
  logic             op_ovf;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic [SHW-1:0]   shamt;

  assign sum   = bus.data1 + bus.data2;
  assign diff  = bus.data1 - bus.data2;
  assign shamt = bus.data2[SHW-1:0];

  always_comb begin
    op_result = '0;
    op_ovf    = 1'b0;
    case (bus.ALUctrl)
      ALU_ADD: begin
        op_result = sum;
        op_ovf    = (bus.data1[WIDTH-1] == bus.data2[WIDTH-1]) &&
                    (sum[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      ALU_SUB: begin
        op_result = diff;
        op_ovf    = (bus.data1[WIDTH-1] != bus.data2[WIDTH-1]) &&
                    (diff[WIDTH-1] != bus.data1[WIDTH-1]);
      end
      ALU_AND: op_result = bus.data1 & bus.data2;
      ALU_OR:  op_result = bus.data1 | bus.data2;
      ALU_SLL: op_result = bus.data1 << shamt;
      ALU_SRL: op_result = bus.data1 >> shamt;
      ALU_XOR: op_result = bus.data1 ^ bus.data2;
      ALU_SLT: op_result = {{(WIDTH-1){1'b0}}, $signed(bus.data1) < $signed(bus.data2)};
      ALU_SRA: op_result = $unsigned($signed(bus.data1) >>> shamt);
      default: op_result = '0;
    endcase
  end

  assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    illegal_d   = illegal_q;
    mul_start   = 1'b0;
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.ALUctrl == ALU_MUL) begin
            state_d   = ST_MUL;
            mul_start = 1'b1;
          end else begin
            result_d    = op_result;
            zero_d      = (op_result == '0);
            ovf_d       = op_ovf;
            illegal_d   = !op_is_legal(bus.ALUctrl);
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        // out_valid is already low here: the MUL accept consumed any prior result
        if (mul_done) begin
          result_d    = mul_product;
          zero_d      = (mul_product == '0);
          ovf_d       = 1'b0;
          illegal_d   = 1'b0;
          out_valid_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      ovf_q       <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      illegal_q   <= illegal_d;
    end
  end

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (mul_start),
    .multiplicand (bus.data1),
    .multiplier   (bus.data2),
    .done         (mul_done),
    .product      (mul_product)
  );

  assign bus.out_valid  = out_valid_q;
  assign bus.alu_result = result_q;
  assign bus.zero       = zero_q;
  assign bus.ovf        = ovf_q;
  assign bus.illegal    = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - scoreboard bench for alu_seq at WIDTH=32
module tb_alu_seq;
  import alu_pkg::*;

  typedef struct packed {
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(32)) bus ();

  alu_seq #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        r;
    logic [32:0] s;
    logic [63:0] p;
    logic [4:0]  sh;
    r  = '0;
    sh = b[4:0];
    case (op)
      ALU_ADD: begin s = {a[31], a} + {b[31], b}; r.result = s[31:0]; r.ovf = s[32] ^ s[31]; end
      ALU_SUB: begin s = {a[31], a} - {b[31], b}; r.result = s[31:0]; r.ovf = s[32] ^ s[31]; end
      ALU_AND: r.result = a & b;
      ALU_OR:  r.result = a | b;
      ALU_SLL: r.result = a << sh;
      ALU_SRL: r.result = a >> sh;
      ALU_XOR: r.result = a ^ b;
      ALU_SLT: r.result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SRA: r.result = (a >> sh) | (a[31] ? ~(32'hFFFF_FFFF >> sh) : 32'h0);
      ALU_MUL: begin p = {32'h0, a} * {32'h0, b}; r.result = p[31:0]; end
      default: r.illegal = 1'b1;
    endcase
    r.zero = (r.result == 32'h0);
    return r;
  endfunction

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.ALUctrl  = op;
    bus.data1    = a;
    bus.data2    = b;
    bus.in_valid = 1'b1;
    sb.push_back(model(op, a, b));
  endtask

  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    drive(op, a, b);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.data1     = '0;
    bus.data2     = '0;
    bus.ALUctrl   = '0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({bus.out_valid, bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b r=%h z=%b o=%b i=%b, expected v=0 r=0 z=1 o=0 i=0",
               bus.out_valid, bus.alu_result, bus.zero, bus.ovf, bus.illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b, expected 1", bus.in_ready);
    end
  endtask

  task automatic test_add_ovf();
    exp_t e;
    send(ALU_ADD, 32'h7FFF_FFFF, 32'h1);
    e = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL add_latency: out_valid got %b, expected 1", bus.out_valid);
    end
    n_checks++;
    if ({bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e) begin
      n_fail++;
      $display("FAIL add_ovf: got %h, expected %h", {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
    n_checks++;
    if (bus.alu_result !== 32'h8000_0000 || bus.ovf !== 1'b1 || bus.zero !== 1'b0) begin
      n_fail++;
      $display("FAIL add_vector: got r=%h o=%b z=%b, expected r=80000000 o=1 z=0", bus.alu_result, bus.ovf, bus.zero);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL add_clear: out_valid got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    drive(ALU_SUB, 32'd5, 32'd5);
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_sub_hs: got v=%b rdy=%b, expected v=1 rdy=1", bus.out_valid, bus.in_ready);
    end
    e = sb.pop_front();
    n_checks++;
    if ({bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e) begin
      n_fail++;
      $display("FAIL b2b_sub: got %h, expected %h", {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
    drive(ALU_SLT, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e) begin
      n_fail++;
      $display("FAIL b2b_slt: got v=%b %h, expected v=1 %h", bus.out_valid,
               {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_clear: out_valid got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_shifts();
    exp_t e;
    send(ALU_SRA, 32'h8000_0000, 32'h24);
    e = sb.pop_front();
    n_checks++;
    if ({bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e || bus.alu_result !== 32'hF800_0000) begin
      n_fail++;
      $display("FAIL sra: got %h, expected %h", {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
    send(ALU_SRL, 32'h8000_0000, 32'h24);
    e = sb.pop_front();
    n_checks++;
    if ({bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e || bus.alu_result !== 32'h0800_0000) begin
      n_fail++;
      $display("FAIL srl: got %h, expected %h", {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
  endtask

  task automatic test_random_ops();
    exp_t        e;
    logic [3:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 32; i++) begin
      op = 4'($urandom_range(0, 15));
      if (op == ALU_MUL) op = ALU_XOR;
      a = $urandom;
      b = $urandom;
      if (i % 4 == 0) a = {a[31], 31'h7FFF_FFFF};
      if (i % 8 == 1) b = a;
      drive(op, a, b);
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || {bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e) begin
        n_fail++;
        $display("FAIL rand_op[%0d] op=%h a=%h b=%h: got v=%b %h, expected v=1 %h", i, op, a, b,
                 bus.out_valid, {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
      end
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_mul();
    exp_t        e;
    logic [31:0] ma[2];
    logic [31:0] mb[2];
    ma[0] = 32'h0001_0001; mb[0] = 32'h0001_0001;
    ma[1] = $urandom;      mb[1] = $urandom;
    for (int m = 0; m < 2; m++) begin
      send(ALU_MUL, ma[m], mb[m]);
      n_checks++;
      if (bus.in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL mul_accept_busy[%0d]: in_ready got %b, expected 0", m, bus.in_ready);
      end
      for (int k = 1; k <= 32; k++) begin
        @(negedge clk);
        n_checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL mul_busy[%0d] edge %0d: got v=%b rdy=%b, expected v=0 rdy=0", m, k, bus.out_valid, bus.in_ready);
        end
      end
      @(negedge clk);
      e = sb.pop_front();
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 ||
          {bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e) begin
        n_fail++;
        $display("FAIL mul_result[%0d]: got v=%b rdy=%b %h, expected v=1 rdy=1 %h", m, bus.out_valid,
                 bus.in_ready, {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_hold_illegal();
    exp_t e;
    bus.out_ready = 1'b0;
    send(ALU_AND, 32'hF0F0_F0F0, 32'hFF00_FF00);
    for (int k = 0; k < 5; k++) begin
      bus.in_valid = 1'b1;
      bus.ALUctrl  = ALU_ADD;
      bus.data1    = 32'd1;
      bus.data2    = 32'd1;
      #1;
      n_checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          {bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== sb[0]) begin
        n_fail++;
        $display("FAIL hold[%0d]: got v=%b rdy=%b %h, expected v=1 rdy=0 %h", k, bus.out_valid,
                 bus.in_ready, {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, sb[0]);
      end
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    e = sb.pop_front();
    drive(4'b1111, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    n_checks++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release_ready: got %b, expected 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e ||
        bus.illegal !== 1'b1 || bus.zero !== 1'b1) begin
      n_fail++;
      $display("FAIL illegal: got v=%b %h, expected v=1 %h", bus.out_valid,
               {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
    @(negedge clk);
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_clear: out_valid got %b, expected 0", bus.out_valid);
    end
  endtask

  task automatic test_reset_mid_mul();
    exp_t e;
    int   stray;
    bus.out_ready = 1'b1;
    send(ALU_ADD, 32'd10, 32'd20);
    e = sb.pop_front();
    send(ALU_MUL, $urandom, $urandom);
    e = sb.pop_back();
    repeat (9) @(negedge clk);
    n_checks++;
    if (bus.alu_result !== 32'd30 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_mul_hold: got v=%b r=%h, expected v=0 r=0000001e", bus.out_valid, bus.alu_result);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.out_valid, bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== {1'b0, 32'h0, 1'b1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: got v=%b r=%h z=%b o=%b i=%b, expected v=0 r=0 z=1 o=0 i=0",
               bus.out_valid, bus.alu_result, bus.zero, bus.ovf, bus.illegal);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_reset: got rdy=%b v=%b, expected rdy=1 v=0", bus.in_ready, bus.out_valid);
    end
    send(ALU_ADD, 32'd2, 32'd3);
    e = sb.pop_front();
    n_checks++;
    if (bus.out_valid !== 1'b1 || {bus.alu_result, bus.zero, bus.ovf, bus.illegal} !== e || bus.alu_result !== 32'd5) begin
      n_fail++;
      $display("FAIL post_reset_add: got v=%b %h, expected v=1 %h", bus.out_valid,
               {bus.alu_result, bus.zero, bus.ovf, bus.illegal}, e);
    end
    stray = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) stray++;
    end
    n_checks++;
    if (stray !== 0) begin
      n_fail++;
      $display("FAIL no_stray_result: got %0d bad cycles, expected 0", stray);
    end
    n_checks++;
    if (sb.size() !== 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d entries left, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_add_ovf();
    test_back_to_back();
    test_shifts();
    test_random_ops();
    test_mul();
    test_hold_illegal();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
